// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
// Used by the round key generator and its S-box.
package aes_pkg;

  localparam int NR_MAX = 10;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } rkg_state_e;

  // Index 0 is unused; Rcon[i] for rounds 1..NR_MAX sits at index i.
  localparam logic [7:0] RCON [NR_MAX+1] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rcon as a full word; rounds outside 1..NR_MAX yield zero.
  function automatic word_t rcon_word(input logic [3:0] round);
    rcon_word = '0;
    if (round != 4'd0 && round <= 4'(NR_MAX)) begin
      rcon_word = {RCON[round], 24'h000000};
    end
  endfunction

endpackage

// File: rtl/round_key_gen_if.sv
// Key-load request and round-key stream between a controller and round_key_gen.
interface round_key_gen_if;

  // Handshake: a round key transfers on a rising clk edge where rk_valid and
  // rk_ready are both 1. While rk_valid=1 and rk_ready=0 the producer holds
  // rk_out/rk_round stable indefinitely. key_load is a request the generator
  // honours only when it is idle (busy=0); otherwise it is dropped.
  aes_pkg::block_t key_in;
  logic            key_load;
  aes_pkg::block_t rk_out;
  logic [3:0]      rk_round;
  logic            rk_valid;
  logic            rk_ready;
  logic            busy;
  logic            done;

  modport master (
    output key_in, key_load, rk_ready,
    input  rk_out, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  key_in, key_load, rk_ready,
    output rk_out, rk_round, rk_valid, busy, done
  );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/round_key_gen.sv
// AES-128 round key generator: expands one round key per accepted transfer
// from a single 128-bit key register, streaming rounds 0..NR to the consumer.
module round_key_gen
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  round_key_gen_if.slave   bus,
  output rkg_state_e       dbg_state
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  rkg_state_e state_q;
  block_t     key_q;
  logic [3:0] round_q;
  logic       done_q;

  word_t  w0, w1, w2, w3;
  word_t  rot_w, sub_w, t_w;
  word_t  n0, n1, n2, n3;
  block_t next_key;

  assign {w0, w1, w2, w3} = key_q;

  // RotWord: byte 0 of w3 moves to the least significant byte position.
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w[8*i +: 8]),
      .dout (sub_w[8*i +: 8])
    );
  end

  assign t_w      = sub_w ^ rcon_word(round_q + 4'd1);
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.key_load) begin
            key_q   <= bus.key_in;
            round_q <= 4'd0;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // key_load is deliberately not looked at here.
          if (bus.rk_ready) begin
            if (round_q == LAST_ROUND) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              key_q   <= next_key;
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rk_out   = key_q;
  assign bus.rk_round = round_q;
  assign bus.rk_valid = (state_q == ST_EMIT);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_round_key_gen.sv
// Scoreboard bench for round_key_gen: a GF(2^8)-arithmetic AES key-expansion
// model fills expected queues; negedge monitors pop and compare each transfer.
module tb_round_key_gen;
  import aes_pkg::*;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst;

  round_key_gen_if bus ();
  round_key_gen_if bus1 ();
  rkg_state_e dbg_state, dbg_state1;

  round_key_gen #(.NR(NR)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  round_key_gen #(.NR(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .dbg_state (dbg_state1)
  );

  // clock/reset
  always #5 clk = ~clk;

  logic [131:0] exp_q[$];
  logic [131:0] exp1_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done1_seen = 0;
  int xfers1 = 0;
  logic [7:0] sbox_m [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] model_round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(r+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_model(input logic [127:0] key);
    for (int r = 0; r <= NR; r++) exp_q.push_back({4'(r), model_round_key(key, r)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_load(input logic [127:0] key);
    bus.key_in   = key;
    bus.key_load = 1'b1;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit spur);
    int start = done_seen;
    for (int c = 0; c < budget && done_seen == start; c++) begin
      bus.rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (spur && exp_q.size() >= 2 && $urandom_range(0, 3) == 0) begin
        bus.key_load = 1'b1;
        bus.key_in   = rand_key();
      end else begin
        bus.key_load = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b1;
    check("session_done", 132'(done_seen != start), 132'(1));
  endtask

  // ---------------- monitors ----------------
  initial begin : mon_main
    logic exp_done = 1'b0;
    logic nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
      end else begin
        check("done", 132'(bus.done), 132'(exp_done));
        nxt = 1'b0;
        if (bus.rk_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_key", {bus.rk_round, bus.rk_out}, 132'hx);
          end else begin
            check("round_key", {bus.rk_round, bus.rk_out}, exp_q[0]);
            if (bus.rk_ready) begin
              if (exp_q[0][131:128] == 4'(NR)) nxt = 1'b1;
              void'(exp_q.pop_front());
            end
          end
        end
        if (bus.done) done_seen++;
        exp_done = nxt;
      end
    end
  end

  initial begin : mon_nr1
    logic exp_done = 1'b0;
    logic nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
      end else begin
        check("nr1_done", 132'(bus1.done), 132'(exp_done));
        nxt = 1'b0;
        if (bus1.rk_valid) begin
          if (exp1_q.size() == 0) begin
            check("nr1_unexpected_key", {bus1.rk_round, bus1.rk_out}, 132'hx);
          end else begin
            check("nr1_round_key", {bus1.rk_round, bus1.rk_out}, exp1_q[0]);
            if (bus1.rk_ready) begin
              if (exp1_q[0][131:128] == 4'd1) nxt = 1'b1;
              void'(exp1_q.pop_front());
              xfers1++;
            end
          end
        end
        if (bus1.done) done1_seen++;
        exp_done = nxt;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [127:0] kat_key;
    logic [127:0] k;
    logic [127:0] v;

    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
    kat_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    rst = 1'b1;
    bus.key_in = '0;  bus.key_load = 1'b0;  bus.rk_ready = 1'b1;
    bus1.key_in = '0; bus1.key_load = 1'b0; bus1.rk_ready = 1'b1;
    #1;
    check("rst_rk_out", 132'(bus.rk_out), 132'(0));
    check("rst_rk_round", 132'(bus.rk_round), 132'(0));
    check("rst_rk_valid", 132'(bus.rk_valid), 132'(0));
    check("rst_busy", 132'(bus.busy), 132'(0));
    check("rst_done", 132'(bus.done), 132'(0));
    check("rst_state", 132'(dbg_state), 132'(ST_IDLE));
    #11 rst = 1'b0;

    // Known-answer session; the first load lands on the first edge after reset.
    for (int r = 0; r <= NR; r++) begin
      v = model_round_key(kat_key, r);
      case (r)
        0:  v = kat_key;
        1:  v = 128'ha0fafe1788542cb123a339392a6c7605;
        2:  v = 128'hf2c295f27a96b9435935807a7359f67f;
        10: v = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        default: ;
      endcase
      exp_q.push_back({4'(r), v});
    end
    pulse_load(kat_key);
    check("first_load_busy", 132'(bus.busy), 132'(1));
    check("first_load_state", 132'(dbg_state), 132'(ST_EMIT));
    check("first_load_round", 132'(bus.rk_round), 132'(0));
    wait_done(100, 1'b0, 1'b0);
    check("idle_round_holds_nr", 132'(bus.rk_round), 132'(NR));

    // Five-cycle stall at round 3.
    push_model(kat_key);
    pulse_load(kat_key);
    repeat (3) begin @(posedge clk); #1; end
    bus.rk_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    wait_done(100, 1'b0, 1'b0);

    // All-zero key_load during round 4 must be ignored.
    push_model(kat_key);
    pulse_load(kat_key);
    repeat (4) begin @(posedge clk); #1; end
    bus.key_in = '0;
    bus.key_load = 1'b1;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    wait_done(100, 1'b0, 1'b0);

    // Asynchronous reset during round 6 aborts the session.
    push_model(kat_key);
    pulse_load(kat_key);
    repeat (6) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_rk_out", 132'(bus.rk_out), 132'(0));
    check("abort_rk_round", 132'(bus.rk_round), 132'(0));
    check("abort_rk_valid", 132'(bus.rk_valid), 132'(0));
    check("abort_busy", 132'(bus.busy), 132'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort_idle", 132'(bus.rk_valid), 132'(0));
    k = rand_key();
    push_model(k);
    pulse_load(k);
    check("restart_round", 132'(bus.rk_round), 132'(0));
    wait_done(100, 1'b0, 1'b0);

    // All-zero key, then a new load issued in the done cycle.
    for (int r = 0; r <= NR; r++) begin
      v = (r == 1) ? 128'h62636363626363636263636362636363 : model_round_key('0, r);
      exp_q.push_back({4'(r), v});
    end
    pulse_load('0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check("done_cycle_reached", 132'(bus.done), 132'(1));
    k = rand_key();
    push_model(k);
    bus.key_in = k;
    bus.key_load = 1'b1;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    check("b2b_valid", 132'(bus.rk_valid), 132'(1));
    check("b2b_round", 132'(bus.rk_round), 132'(0));
    wait_done(100, 1'b0, 1'b0);

    // Random keys, random backpressure, spurious loads mid-session.
    repeat (6) begin
      k = rand_key();
      push_model(k);
      pulse_load(k);
      wait_done(400, 1'b1, 1'b1);
    end

    // NR=1 build: exactly rounds 0 and 1, then done.
    k = rand_key();
    exp1_q.push_back({4'd0, model_round_key(k, 0)});
    exp1_q.push_back({4'd1, model_round_key(k, 1)});
    bus1.key_in = k;
    bus1.key_load = 1'b1;
    @(posedge clk); #1;
    bus1.key_load = 1'b0;
    for (int c = 0; c < 20 && done1_seen == 0; c++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    check("nr1_transfers", 132'(xfers1), 132'(2));
    check("nr1_done_count", 132'(done1_seen), 132'(1));
    check("nr1_idle", 132'(bus1.rk_valid), 132'(0));

    // final report
    check("queue_drained", 132'(exp_q.size()), 132'(0));
    check("nr1_queue_drained", 132'(exp1_q.size()), 132'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
